clock_display_scan: RTL and testbench

Multiplexed six-digit seven-segment driver for the clock's HH:MM:SS counters. It reads the binary hour, minute and second values and splits each into BCD tens and ones. It scans the six digits at a fixed rate and blanks the field under adjustment at a blink rate. Inputs are snapshotted once per scan frame, so a carry ripple between counters never shows up as a torn display.

---
 rtl/clock_display_scan.sv | 126 ++++++++++++
 tb/tb_clock_display_scan.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/clock_display_scan.sv
// Six-digit multiplexed seven-segment driver for HH:MM:SS. The display reads from a snapshot
// that is refreshed only at the frame wrap, so a carry ripple never shows up half-applied.
module clock_display_scan #(
    parameter int SCAN_DIV     = 1000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic       clk,
    input  logic       clear,
    input  logic [5:0] hours,
    input  logic [5:0] minutes,
    input  logic [5:0] seconds,
    input  logic       adjust,
    input  logic [1:0] adj_sel,
    output logic [5:0] an,
    output logic [6:0] seg,
    output logic       frame
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    localparam logic [6:0] GLYPH_DASH = 7'b1000000;
    localparam logic [6:0] GLYPH_ZERO = 7'b0111111;

    logic [PW-1:0] presc;
    logic [2:0]    idx;
    logic [5:0]    snap_h, snap_m, snap_s;
    logic [BW-1:0] blink_cnt;
    logic          blink_phase;

    logic tick, wrap;

    assign tick  = (presc == PRESC_LAST);
    assign wrap  = tick && (idx == 3'd5);
    assign frame = wrap;

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            presc       <= '0;
            idx         <= 3'd0;
            snap_h      <= 6'd0;
            snap_m      <= 6'd0;
            snap_s      <= 6'd0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            presc <= tick ? '0 : presc + PW'(1);
            if (tick)
                idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
            if (wrap) begin
                snap_h <= hours;
                snap_m <= minutes;
                snap_s <= seconds;
                if (blink_cnt == BLINK_LAST) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + BW'(1);
                end
            end
        end
    end

    // Digit pipeline: pick the field for the current index, split to BCD, map to a glyph.
    logic [1:0] field;
    logic [5:0] value;
    logic       legal;
    logic [3:0] tens, ones, digit;
    logic       blank;
    logic [6:0] glyph, seg_next;
    logic [5:0] an_next;

    always_comb begin
        field = idx[2:1];
        case (field)
            2'd0:    begin value = snap_s; legal = (snap_s < 6'd60); end
            2'd1:    begin value = snap_m; legal = (snap_m < 6'd60); end
            default: begin value = snap_h; legal = (snap_h < 6'd24); end
        endcase

        // Values never exceed 63, so a compare chain replaces a divider.
        if      (value >= 6'd60) begin tens = 4'd6; ones = 4'(value - 6'd60); end
        else if (value >= 6'd50) begin tens = 4'd5; ones = 4'(value - 6'd50); end
        else if (value >= 6'd40) begin tens = 4'd4; ones = 4'(value - 6'd40); end
        else if (value >= 6'd30) begin tens = 4'd3; ones = 4'(value - 6'd30); end
        else if (value >= 6'd20) begin tens = 4'd2; ones = 4'(value - 6'd20); end
        else if (value >= 6'd10) begin tens = 4'd1; ones = 4'(value - 6'd10); end
        else                     begin tens = 4'd0; ones = value[3:0];        end

        digit = idx[0] ? tens : ones;

        case (digit)
            4'd0:    glyph = 7'b0111111;
            4'd1:    glyph = 7'b0000110;
            4'd2:    glyph = 7'b1011011;
            4'd3:    glyph = 7'b1001111;
            4'd4:    glyph = 7'b1100110;
            4'd5:    glyph = 7'b1101101;
            4'd6:    glyph = 7'b1111101;
            4'd7:    glyph = 7'b0000111;
            4'd8:    glyph = 7'b1111111;
            default: glyph = 7'b1101111;
        endcase

        blank = adjust && blink_phase && (adj_sel != 2'd3) && (adj_sel == field);

        if (blank)       seg_next = 7'b0000000;
        else if (!legal) seg_next = GLYPH_DASH;
        else             seg_next = glyph;

        an_next = 6'b000001 << idx;
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            an  <= 6'b000001;
            seg <= GLYPH_ZERO;
        end else begin
            an  <= an_next;
            seg <= seg_next;
        end
    end

endmodule

// File: tb/tb_clock_display_scan.sv
// Directed bench for clock_display_scan with SCAN_DIV = 4, BLINK_FRAMES = 2 (24-cycle frames,
// 48-cycle blink half-period). Cycle 0 is the first cycle after clear releases.
module tb_clock_display_scan;

    localparam logic [6:0] G0 = 7'b0111111;
    localparam logic [6:0] G1 = 7'b0000110;
    localparam logic [6:0] G2 = 7'b1011011;
    localparam logic [6:0] G3 = 7'b1001111;
    localparam logic [6:0] G4 = 7'b1100110;
    localparam logic [6:0] G5 = 7'b1101101;
    localparam logic [6:0] G6 = 7'b1111101;
    localparam logic [6:0] G7 = 7'b0000111;
    localparam logic [6:0] G8 = 7'b1111111;
    localparam logic [6:0] G9 = 7'b1101111;
    localparam logic [6:0] GD = 7'b1000000;
    localparam logic [6:0] GB = 7'b0000000;

    logic       clk;
    logic       clear;
    logic [5:0] hours, minutes, seconds;
    logic       adjust;
    logic [1:0] adj_sel;
    logic [5:0] an;
    logic [6:0] seg;
    logic       frame;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    clock_display_scan #(.SCAN_DIV(4), .BLINK_FRAMES(2)) dut (
        .clk     (clk),
        .clear   (clear),
        .hours   (hours),
        .minutes (minutes),
        .seconds (seconds),
        .adjust  (adjust),
        .adj_sel (adj_sel),
        .an      (an),
        .seg     (seg),
        .frame   (frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected glyphs for one frame, digit 0 in the low seven bits.
    function automatic logic [41:0] fr(input logic [6:0] d0, d1, d2, d3, d4, d5);
        return {d5, d4, d3, d2, d1, d0};
    endfunction

    task automatic check_out(input string tag, input logic [5:0] exp_an,
                             input logic [6:0] exp_seg, input logic exp_frame);
        compared++;
        assert (an === exp_an) else begin
            mismatched++;
            $error("FAIL %s an cyc=%0d observed=%b expected=%b", tag, cyc, an, exp_an);
        end
        compared++;
        assert (seg === exp_seg) else begin
            mismatched++;
            $error("FAIL %s seg cyc=%0d observed=%b expected=%b", tag, cyc, seg, exp_seg);
        end
        compared++;
        assert (frame === exp_frame) else begin
            mismatched++;
            $error("FAIL %s frame cyc=%0d observed=%b expected=%b", tag, cyc, frame, exp_frame);
        end
    endtask

    // Advance n cycles; in cycle c the outputs show the digit indexed during cycle c-1.
    task automatic run(input string tag, input int n, input logic [41:0] exp_digits);
        int d;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            d = ((cyc - 1) / 4) % 6;
            check_out(tag, 6'(1 << d), exp_digits[d*7 +: 7], (cyc % 24) == 23);
        end
    endtask

    initial begin
        logic [41:0] zeros, normal, min_blank, sec_blank;
        zeros     = fr(G0, G0, G0, G0, G0, G0);
        normal    = fr(G6, G5, G4, G3, G2, G1);
        min_blank = fr(G6, G5, GB, GB, G2, G1);
        sec_blank = fr(GB, GB, G4, G3, G2, G1);

        clear   = 1'b1;
        hours   = 6'd0;
        minutes = 6'd0;
        seconds = 6'd0;
        adjust  = 1'b0;
        adj_sel = 2'd3;

        repeat (3) @(posedge clk);
        #1;
        check_out("reset", 6'b000001, G0, 1'b0);

        clear   = 1'b0;
        cyc     = 0;
        hours   = 6'd12;
        minutes = 6'd34;
        seconds = 6'd56;
        check_out("release", 6'b000001, G0, 1'b0);
        run("scan0", 24, zeros);

        hours   = 6'd12;
        minutes = 6'd7;
        seconds = 6'd59;
        run("decode", 24, normal);

        run("tear_old", 11, fr(G9, G5, G7, G0, G2, G1));
        minutes = 6'd8;
        seconds = 6'd0;
        run("tear_old", 13, fr(G9, G5, G7, G0, G2, G1));

        run("tear_new", 7, fr(G0, G0, G8, G0, G2, G1));
        hours   = 6'd24;
        minutes = 6'd34;
        seconds = 6'd60;
        run("tear_new", 17, fr(G0, G0, G8, G0, G2, G1));

        run("illegal", 3, fr(GD, GD, G4, G3, GD, GD));
        hours   = 6'd12;
        minutes = 6'd34;
        seconds = 6'd56;
        adjust  = 1'b1;
        adj_sel = 2'd1;
        run("illegal", 21, fr(GD, GD, G4, G3, GD, GD));

        run("blink_on0", 24, normal);
        run("blink_off", 48, min_blank);
        run("blink_on1", 48, normal);

        adj_sel = 2'd3;
        run("sel_none", 24, normal);
        adj_sel = 2'd0;
        run("sel_sec", 24, sec_blank);

        run("pre_clear", 12, normal);
        clear = 1'b1;
        #1;
        check_out("clear_async", 6'b000001, G0, 1'b0);
        @(posedge clk);
        #1;
        check_out("clear_hold", 6'b000001, G0, 1'b0);
        @(posedge clk);
        #1;
        check_out("clear_hold", 6'b000001, G0, 1'b0);

        clear = 1'b0;
        cyc   = 0;
        check_out("release2", 6'b000001, G0, 1'b0);
        run("scan1", 24, zeros);
        run("scan1_dec", 24, sec_blank & normal | normal);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
